// File: rtl/dft_pkg.sv
// rtl/dft_pkg.sv - shared state encoding, default widths and the saturating round helper
package dft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ROUND,
    OUTPUT
  } state_e;

  // Round-half-up by frac_w bits, then clip into a data_w two's complement range.
  function automatic logic signed [63:0] sat_round(
    input  logic signed [63:0] acc,
    input  int                 frac_w,
    input  int                 data_w,
    output logic               clip
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r    = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo   = -(64'sd1 <<< (data_w - 1));
    clip = 1'b0;
    if (r > hi) begin
      r    = hi;
      clip = 1'b1;
    end else if (r < lo) begin
      r    = lo;
      clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/complex_mac.sv
// rtl/complex_mac.sv - read-align, registered complex product and accumulate stages
module complex_mac
  import dft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int ACC_W  = DATA_W_DEF + TW_W_DEF + ADDR_W_DEF + 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clr,
  input  logic                     issue_valid,
  input  logic                     issue_first,
  input  logic [2*DATA_W-1:0]      samp_data,
  input  logic [2*TW_W-1:0]        tw_data,
  output logic signed [ACC_W-1:0]  acc_re,
  output logic signed [ACC_W-1:0]  acc_im
);

  logic rd_vld_q, rd_vld_d, rd_first_q, rd_first_d;
  logic prod_vld_q, prod_vld_d, prod_first_q, prod_first_d;
  logic signed [ACC_W-1:0] prod_re_q, prod_re_d, prod_im_q, prod_im_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;

  logic signed [DATA_W-1:0] a_re, a_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [DATA_W+TW_W-1:0] p_rr, p_ii, p_ri, p_ir;

  assign a_re = samp_data[2*DATA_W-1:DATA_W];
  assign a_im = samp_data[DATA_W-1:0];
  assign w_re = tw_data[2*TW_W-1:TW_W];
  assign w_im = tw_data[TW_W-1:0];

  always_comb begin
    p_rr = a_re * w_re;
    p_ii = a_im * w_im;
    p_ri = a_re * w_im;
    p_ir = a_im * w_re;

    rd_vld_d     = issue_valid & ~clr;
    rd_first_d   = issue_first;
    prod_vld_d   = rd_vld_q & ~clr;
    prod_first_d = rd_first_q;
    prod_re_d    = ACC_W'(p_rr) - ACC_W'(p_ii);
    prod_im_d    = ACC_W'(p_ri) + ACC_W'(p_ir);

    // The first product of a bin overwrites the sum, so no clearing cycle is needed.
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (prod_vld_q) begin
      acc_re_d = prod_first_q ? prod_re_q : acc_re_q + prod_re_q;
      acc_im_d = prod_first_q ? prod_im_q : acc_im_q + prod_im_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_vld_q     <= 1'b0;
      rd_first_q   <= 1'b0;
      prod_vld_q   <= 1'b0;
      prod_first_q <= 1'b0;
      prod_re_q    <= '0;
      prod_im_q    <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
    end else begin
      rd_vld_q     <= rd_vld_d;
      rd_first_q   <= rd_first_d;
      prod_vld_q   <= prod_vld_d;
      prod_first_q <= prod_first_d;
      prod_re_q    <= prod_re_d;
      prod_im_q    <= prod_im_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;

endmodule

// File: rtl/dft_mac_engine.sv
// rtl/dft_mac_engine.sv - direct DFT engine: bin sequencing FSM, sample/twiddle index generation, rounding
module dft_mac_engine
  import dft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ACC_W  = DATA_W + TW_W + ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     samp_number,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_flag,
  output logic                  samp_rd_en,
  output logic [ADDR_W-1:0]     samp_rd_addr,
  input  logic [2*DATA_W-1:0]   samp_rd_data,
  output logic                  tw_rd_en,
  output logic [ADDR_W-1:0]     tw_rd_addr,
  input  logic [2*TW_W-1:0]     tw_rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*DATA_W-1:0]   res_data,
  output logic [ADDR_W-1:0]     res_index
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] num_q, num_d, n_q, n_d, idx_q, idx_d, k_q, k_d;
  logic [ADDR_W-1:0] res_index_q, res_index_d;
  logic [1:0]        drain_q, drain_d;
  logic              rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_re_q, res_re_d, res_im_q, res_im_d;

  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [63:0]      rnd_re, rnd_im;
  logic                    clip_re, clip_im;
  logic [ADDR_W:0]         idx_sum;
  logic                    last_n, last_k;

  complex_mac #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk         (clk),
    .nrst        (nrst),
    .clr         (mac_clr),
    .issue_valid (rd_en_q),
    .issue_first (rd_en_q && (n_q == '0)),
    .samp_data   (samp_rd_data),
    .tw_data     (tw_rd_data),
    .acc_re      (acc_re),
    .acc_im      (acc_im)
  );

  assign last_n = (n_q == num_q - ADDR_W'(1));
  assign last_k = (k_q == num_q - ADDR_W'(1));

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    n_d         = n_q;
    idx_d       = idx_q;
    k_d         = k_q;
    drain_d     = drain_q;
    rd_en_d     = rd_en_q;
    done_d      = 1'b0;
    sat_d       = sat_q;
    res_valid_d = res_valid_q;
    res_re_d    = res_re_q;
    res_im_d    = res_im_q;
    res_index_d = res_index_q;
    mac_clr     = 1'b0;

    rnd_re = sat_round(64'(acc_re), TW_W - 1, DATA_W, clip_re);
    rnd_im = sat_round(64'(acc_im), TW_W - 1, DATA_W, clip_im);

    // Twiddle index steps by k modulo N; both operands are below N so one subtract suffices.
    idx_sum = {1'b0, idx_q} + {1'b0, k_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          sat_d = 1'b0;
          num_d = samp_number;
          n_d   = '0;
          idx_d = '0;
          k_d   = '0;
          if (samp_number == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (last_n) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          drain_d = '0;
          n_d     = '0;
          idx_d   = '0;
        end else begin
          n_d   = n_q + ADDR_W'(1);
          idx_d = (idx_sum >= {1'b0, num_q}) ? ADDR_W'(idx_sum - {1'b0, num_q}) : ADDR_W'(idx_sum);
        end
      end
      DRAIN: begin
        if (drain_q == 2'd2) state_d = ROUND;
        else                 drain_d = drain_q + 2'd1;
      end
      ROUND: begin
        res_re_d    = DATA_W'(rnd_re);
        res_im_d    = DATA_W'(rnd_im);
        res_index_d = k_q;
        res_valid_d = 1'b1;
        sat_d       = sat_q | clip_re | clip_im;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (last_k) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + ADDR_W'(1);
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      rd_en_d     = 1'b0;
      res_valid_d = 1'b0;
      done_d      = 1'b0;
      n_d         = '0;
      idx_d       = '0;
      mac_clr     = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sat_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      res_index_q <= '0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sat_q       <= sat_d;
      res_valid_q <= res_valid_d;
      res_re_q    <= res_re_d;
      res_im_q    <= res_im_d;
      res_index_q <= res_index_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign sat_flag     = sat_q;
  assign samp_rd_en   = rd_en_q;
  assign tw_rd_en     = rd_en_q;
  assign samp_rd_addr = n_q;
  assign tw_rd_addr   = idx_q;
  assign res_valid    = res_valid_q;
  assign res_data     = {res_re_q, res_im_q};
  assign res_index    = res_index_q;

endmodule

// File: doc/dft_mac_engine.md
DFT_MAC_ENGINE -- requirements
Module: dft_mac_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample real/imag width, two's complement.
REQ-002 SHALL have parameter TW_W, default 16, meaning twiddle real/imag width, Q1.(TW_W-1).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning sample index width (N max 2^ADDR_W-1).
REQ-004 SHALL have parameter ACC_W, default DATA_W+TW_W+ADDR_W+1, meaning accumulator width per component.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port nrst  input  1  meaning reset, asynchronous, active-low.
REQ-007 SHALL have ports start input 1 (begin transform) and abort input 1 (synchronous cancel).
REQ-008 SHALL have port samp_number  input  ADDR_W  meaning N, sampled on start acceptance.
REQ-009 SHALL have ports busy output 1, done output 1 (one-cycle pulse) and sat_flag output 1 (sticky saturation).
REQ-010 SHALL have ports samp_rd_en output 1, samp_rd_addr output ADDR_W and samp_rd_data input 2*DATA_W {re,im}; read data valid exactly 1 cycle after samp_rd_en.
REQ-011 SHALL have ports tw_rd_en output 1, tw_rd_addr output ADDR_W and tw_rd_data input 2*TW_W {re,im}; read data valid 1 cycle after tw_rd_en.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1, res_data output 2*DATA_W {re,im} and res_index output ADDR_W (bin k).

Function
REQ-013 SHALL compute X[k] = sum over n=0..N-1 of x[n]*W[(n*k) mod N] for k=0..N-1, emitting bins in ascending k.
REQ-014 SHALL use FSM states IDLE, FETCH, DRAIN, ROUND, OUTPUT, with transitions IDLE->FETCH on start; FETCH->DRAIN after n=N-1 issue; DRAIN (3 cycles)->ROUND; ROUND->OUTPUT; OUTPUT->FETCH (k<N-1) or ->IDLE with done (k=N-1) on res_valid&&res_ready.
REQ-015 SHALL accept start only in IDLE, ignoring start while busy; busy=1 in every state except IDLE.
REQ-016 SHALL, in FETCH, assert samp_rd_en and tw_rd_en every cycle with samp_rd_addr=n and tw_rd_addr=idx, where idx starts at 0 per bin and updates idx=(idx+k) mod N via compare-subtract, with no multiplier.
REQ-017 SHALL pipeline each product as read (1 cycle) -> registered complex product (1 cycle) -> accumulate (1 cycle): re=a_re*w_re-a_im*w_im, im=a_re*w_im+a_im*w_re, sign-extended to ACC_W.
REQ-018 SHALL clear the accumulator on the first product of each bin, not by a separate cycle.
REQ-019 SHALL form ROUND output as (acc + 2^(TW_W-2)) >>> (TW_W-1), saturated to DATA_W, setting sat_flag if either component clips.
REQ-020 SHALL hold res_data and res_index stable while res_valid=1 and res_ready=0; the transfer occurs on the edge where both are 1.
REQ-021 SHALL make per-bin latency N+5 cycles minimum (N FETCH, 3 DRAIN, 1 ROUND, >=1 OUTPUT).
REQ-022 SHALL, for N=0, pulse done the cycle after start with no results; N=1 SHALL yield a single bin X[0]=x[0]*W[0].
REQ-023 SHALL, on abort in any non-IDLE state, return to IDLE next cycle, deassert res_valid and all read enables, and not pulse done; abort in IDLE SHALL be ignored.
REQ-024 SHALL clear sat_flag on start acceptance; if start and abort coincide in IDLE, start SHALL win.

Reset
REQ-025 SHALL force, on nrst=0, state=IDLE and busy, done, sat_flag, res_valid, samp_rd_en and tw_rd_en=0, with all addresses, res_data, res_index, counters and accumulator=0.
REQ-026 SHALL abandon a transform on reset mid-operation with no output after release until a new start.

Structure
REQ-027 SHALL place the state enum, default parameter values and the saturating round function in package dft_pkg.
REQ-028 SHALL implement the product/accumulate pipeline (REQ-017/018) as sub-module complex_mac; the FSM, counters and index generator stay in dft_mac_engine.

Verification
REQ-029 SHALL cover: N=4, x={1000,0,0,0}, W=ideal Q1.15 -> 4 bins each 1000+j0, done once.
REQ-030 SHALL cover: N=4, x all 1000+j0 -> X[0]=4000+j0, X[1..3]=0 (+/-1 LSB).
REQ-031 SHALL cover: res_ready low 5 cycles at bin 2 -> res_data/res_index unchanged over those cycles, no bin lost or duplicated.
REQ-032 SHALL cover: N=8, x all 32767+j0 -> X[0]=32767 saturated, sat_flag=1 until next start.
REQ-033 SHALL cover: abort during FETCH of bin 1, then start with N=2 -> clean IDLE, then 2 correct bins; start pulsed while busy is ignored.
REQ-034 SHALL cover: nrst asserted during DRAIN -> all outputs 0 asynchronously, no res_valid after release.
